// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - control and status bundle between the cpu top and the stage sequencer
interface stage_sequencer_if #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) ();
    localparam int IDXW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              stall;
    logic [STAGES-1:0] skip_mask;
    logic              mem_req;
    logic              mem_ready;
    logic              halt_req;
    logic              err_clr;
    logic [STAGES-1:0] stage_en;
    logic [IDXW-1:0]   stage_idx;
    logic              inst_retired;
    logic [CNT_W-1:0]  retired_count;
    logic              halted;
    logic              bus_error;

    // cpu top side: issues control, observes sequencing status
    modport master (
        output stall, skip_mask, mem_req, mem_ready, halt_req, err_clr,
        input  stage_en, stage_idx, inst_retired, retired_count, halted, bus_error
    );

    // sequencer side
    modport slave (
        input  stall, skip_mask, mem_req, mem_ready, halt_req, err_clr,
        output stage_en, stage_idx, inst_retired, retired_count, halted, bus_error
    );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-hot pipeline stage sequencer with skip mask, memory wait, timeout and halt
module stage_sequencer #(
    parameter int STAGES       = 5,
    parameter int DECODE_STAGE = 1,
    parameter int MEM_STAGE    = 3,
    parameter int TIMEOUT      = 15,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    stage_sequencer_if.slave  bus
);
    localparam int IDXW = (STAGES > 1) ? $clog2(STAGES) : 1;
    // wait counter only needs to reach TIMEOUT; it saturates when TIMEOUT=0
    localparam int WCW  = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] stage_en_q, stage_en_d;
    logic [IDXW-1:0]   stage_idx_q, stage_idx_d;
    logic [STAGES-1:0] mask_q, mask_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              inst_retired_q, inst_retired_d;
    logic [CNT_W-1:0]  retired_count_q, retired_count_d;
    logic              halted_q, halted_d;
    logic              bus_error_q, bus_error_d;

    logic [STAGES-1:0] eff_mask;
    logic              nxt_found;
    logic [IDXW-1:0]   nxt_idx;
    logic              mem_wait;

    assign bus.stage_en      = stage_en_q;
    assign bus.stage_idx     = stage_idx_q;
    assign bus.inst_retired  = inst_retired_q;
    assign bus.retired_count = retired_count_q;
    assign bus.halted        = halted_q;
    assign bus.bus_error     = bus_error_q;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_START;
            stage_en_q      <= '0;
            stage_idx_q     <= '0;
            mask_q          <= '0;
            wait_cnt_q      <= '0;
            inst_retired_q  <= 1'b0;
            retired_count_q <= '0;
            halted_q        <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            stage_en_q      <= stage_en_d;
            stage_idx_q     <= stage_idx_d;
            mask_q          <= mask_d;
            wait_cnt_q      <= wait_cnt_d;
            inst_retired_q  <= inst_retired_d;
            retired_count_q <= retired_count_d;
            halted_q        <= halted_d;
            bus_error_q     <= bus_error_d;
        end
    end

    // Next-state logic: stage advance, skip search, memory wait/timeout, retire and halt
    always_comb begin
        state_d         = state_q;
        stage_en_d      = stage_en_q;
        stage_idx_d     = stage_idx_q;
        mask_d          = mask_q;
        wait_cnt_d      = wait_cnt_q;
        inst_retired_d  = 1'b0;
        retired_count_d = retired_count_q;
        halted_d        = halted_q;
        bus_error_d     = bus_error_q;
        nxt_found       = 1'b0;
        nxt_idx         = '0;

        // the live decoder mask applies while leaving decode; afterwards the latched copy
        eff_mask = (stage_idx_q == IDXW'(DECODE_STAGE)) ? bus.skip_mask : mask_q;
        for (int j = 0; j <= DECODE_STAGE; j++) begin
            eff_mask[j] = 1'b0;
        end

        // first non-skipped stage after the current one; none found means retire
        for (int j = 1; j < STAGES; j++) begin
            if (!nxt_found && (j > int'(stage_idx_q)) && !eff_mask[j]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDXW'(j);
            end
        end

        mem_wait = (stage_idx_q == IDXW'(MEM_STAGE)) && bus.mem_req && !bus.mem_ready;

        // clear first so that a timeout in the same cycle still sets the flag
        if (bus.err_clr) begin
            bus_error_d = 1'b0;
        end

        case (state_q)
            ST_START: begin
                state_d     = ST_RUN;
                stage_idx_d = '0;
                stage_en_d  = STAGES'(1);
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (mem_wait) begin
                        if ((TIMEOUT > 0) && (wait_cnt_q == WCW'(TIMEOUT))) begin
                            // abandon the instruction without retiring it
                            bus_error_d = 1'b1;
                            wait_cnt_d  = '0;
                            stage_idx_d = '0;
                            stage_en_d  = STAGES'(1);
                        end else if (wait_cnt_q != {WCW{1'b1}}) begin
                            wait_cnt_d = wait_cnt_q + WCW'(1);
                        end
                    end else begin
                        wait_cnt_d = '0;
                        if (stage_idx_q == IDXW'(DECODE_STAGE)) begin
                            mask_d = eff_mask;
                        end
                        if (nxt_found) begin
                            stage_idx_d = nxt_idx;
                            stage_en_d  = STAGES'(1) << nxt_idx;
                        end else begin
                            inst_retired_d  = 1'b1;
                            retired_count_d = retired_count_q + CNT_W'(1);
                            stage_idx_d     = '0;
                            if (bus.halt_req) begin
                                state_d    = ST_HALT;
                                stage_en_d = '0;
                                halted_d   = 1'b1;
                            end else begin
                                stage_en_d = STAGES'(1);
                            end
                        end
                    end
                end
            end
            ST_HALT: begin
                if (!bus.halt_req) begin
                    state_d     = ST_RUN;
                    stage_idx_d = '0;
                    stage_en_d  = STAGES'(1);
                    halted_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer
module tb_stage_sequencer;
    localparam int STAGES = 5;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [4:0] en;
        logic       ret;
        logic [3:0] cnt;
        logic       hlt;
        logic       be;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    string      phase = "init";
    logic [3:0] exp_cnt  = 4'd0;
    logic       exp_halt = 1'b0;
    logic       exp_be   = 1'b0;

    always #5 clk = ~clk;

    stage_sequencer_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

    stage_sequencer #(
        .STAGES(STAGES), .DECODE_STAGE(1), .MEM_STAGE(3), .TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] enc(input logic [4:0] en);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (en[i]) r = 3'(i);
        end
        return r;
    endfunction

    // push the expectation for the next edge, then compare once the DUT has produced it
    task automatic cyc(input logic [4:0] en, input logic ret);
        exp_t e;
        if (ret) exp_cnt = exp_cnt + 4'd1;
        e.en = en; e.ret = ret; e.cnt = exp_cnt; e.hlt = exp_halt; e.be = exp_be;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("stage_en",      32'(bus.stage_en),      32'(e.en));
        check_eq("stage_idx",     32'(bus.stage_idx),     32'(enc(e.en)));
        check_eq("inst_retired",  32'(bus.inst_retired),  32'(e.ret));
        check_eq("retired_count", 32'(bus.retired_count), 32'(e.cnt));
        check_eq("halted",        32'(bus.halted),        32'(e.hlt));
        check_eq("bus_error",     32'(bus.bus_error),     32'(e.be));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0; bus.skip_mask = '0; bus.mem_req = 1'b0;
        bus.mem_ready = 1'b0; bus.halt_req = 1'b0; bus.err_clr = 1'b0;

        phase = "reset";
        cyc(5'b00000, 1'b0);
        rst = 1'b0;

        phase = "plain";
        cyc(5'b00001, 0); cyc(5'b00010, 0); cyc(5'b00100, 0);
        cyc(5'b01000, 0); cyc(5'b10000, 0); cyc(5'b00001, 1);

        phase = "skip_mem";
        bus.skip_mask = 5'b01000;
        cyc(5'b00010, 0); cyc(5'b00100, 0); cyc(5'b10000, 0); cyc(5'b00001, 1);
        phase = "skip_all";
        bus.skip_mask = 5'b11100;
        cyc(5'b00010, 0); cyc(5'b00001, 1);
        bus.skip_mask = '0;

        phase = "mem_wait";
        bus.mem_req = 1'b1;
        cyc(5'b00010, 0); cyc(5'b00100, 0);
        repeat (4) cyc(5'b01000, 0);
        bus.mem_ready = 1'b1;
        cyc(5'b10000, 0);
        bus.mem_ready = 1'b0; bus.mem_req = 1'b0;
        cyc(5'b00001, 1);

        phase = "timeout";
        bus.mem_req = 1'b1;
        cyc(5'b00010, 0); cyc(5'b00100, 0);
        repeat (5) cyc(5'b01000, 0);
        exp_be = 1'b1;
        cyc(5'b00001, 0);
        bus.mem_req = 1'b0; bus.err_clr = 1'b1; exp_be = 1'b0;
        cyc(5'b00010, 0);
        bus.err_clr = 1'b0;
        cyc(5'b00100, 0); cyc(5'b01000, 0); cyc(5'b10000, 0); cyc(5'b00001, 1);

        phase = "set_beats_clr";
        bus.mem_req = 1'b1; bus.err_clr = 1'b1;
        cyc(5'b00010, 0); cyc(5'b00100, 0);
        repeat (5) cyc(5'b01000, 0);
        exp_be = 1'b1;
        cyc(5'b00001, 0);
        bus.err_clr = 1'b0;
        phase = "ready_at_limit";
        cyc(5'b00010, 0); cyc(5'b00100, 0);
        repeat (5) cyc(5'b01000, 0);
        bus.mem_ready = 1'b1;
        cyc(5'b10000, 0);
        bus.mem_ready = 1'b0; bus.mem_req = 1'b0; bus.err_clr = 1'b1; exp_be = 1'b0;
        cyc(5'b00001, 1);
        bus.err_clr = 1'b0;

        phase = "stall_halt";
        bus.halt_req = 1'b1;
        cyc(5'b00010, 0); cyc(5'b00100, 0);
        bus.stall = 1'b1;
        cyc(5'b00100, 0); cyc(5'b00100, 0);
        bus.stall = 1'b0;
        cyc(5'b01000, 0); cyc(5'b10000, 0);
        exp_halt = 1'b1;
        cyc(5'b00000, 1); cyc(5'b00000, 0);
        bus.halt_req = 1'b0; exp_halt = 1'b0;
        cyc(5'b00001, 0);

        phase = "count_wrap";
        bus.skip_mask = 5'b11100;
        for (int i = 0; i < 16; i++) begin
            cyc(5'b00010, 0); cyc(5'b00001, 1);
        end
        bus.skip_mask = '0;

        phase = "reset_mid_mem";
        bus.mem_req = 1'b1;
        cyc(5'b00010, 0); cyc(5'b00100, 0); cyc(5'b01000, 0); cyc(5'b01000, 0);
        rst = 1'b1; exp_cnt = 4'd0; exp_be = 1'b0; exp_halt = 1'b0;
        cyc(5'b00000, 0);
        rst = 1'b0; bus.mem_req = 1'b0;
        cyc(5'b00001, 0); cyc(5'b00010, 0); cyc(5'b00100, 0);
        cyc(5'b01000, 0); cyc(5'b10000, 0); cyc(5'b00001, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
